// File: rtl/pow_pkg.sv
// Shared types for the modular exponentiation unit and its multiplier.
package pow_pkg;

   // Top-level sequencing: reduce the base, then LSB-first square-and-multiply.
   typedef enum logic [2:0] {
      IDLE,
      REDUCE,
      MUL_A,
      MUL_X,
      DONE
   } pow_state_t;

   // Interleaved multiplier: idle, or stepping through multiplier bits.
   typedef enum logic {
      M_IDLE,
      M_RUN
   } mult_state_t;

endpackage

// File: rtl/mod_mult.sv
// Sequential interleaved modular multiplier: p = a*b mod m in exactly W cycles.
// The start cycle already performs the first (MSB) step from the port operands,
// so a new multiply can be chained on the cycle that 'done' is seen.
// m is W+1 bits so that 2^W (wrap-around mode) is representable; a must be < m.
module mod_mult
   import pow_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         clear,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W:0]   m,
   output logic         done,
   output logic [W-1:0] p
);

   localparam int CW = $clog2(W);

   mult_state_t   ms, ms_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [W:0]    acc, acc_nx;
   logic [W:0]    a_q, a_nx;
   logic [W:0]    m_q, m_nx;
   logic [W-1:0]  b_q, b_nx;
   logic          done_nx;

   // One interleaved step: r = 2r mod m, then r = r + a mod m when the bit is set.
   // With r, a < m <= 2^W every intermediate fits in W+1 bits.
   function automatic logic [W:0] step(input logic [W:0] r, input logic [W:0] ad,
                                       input logic [W:0] md, input logic bit_i);
      logic [W:0] t;
      t = r << 1;
      if (t >= md) t = t - md;
      if (bit_i)   t = t + ad;
      if (t >= md) t = t - md;
      return t;
   endfunction

   // Next-state and datapath: clear beats start, start beats an ongoing run.
   always_comb begin
      ms_nx   = ms;
      cnt_nx  = cnt;
      acc_nx  = acc;
      a_nx    = a_q;
      b_nx    = b_q;
      m_nx    = m_q;
      done_nx = 1'b0;
      if (clear) begin
         ms_nx  = M_IDLE;
         cnt_nx = '0;
         acc_nx = '0;
      end else if (start) begin
         ms_nx  = M_RUN;
         a_nx   = {1'b0, a};
         m_nx   = m;
         b_nx   = b << 1;
         cnt_nx = CW'(W - 1);
         acc_nx = step('0, {1'b0, a}, m, b[W-1]);
      end else if (ms == M_RUN) begin
         acc_nx = step(acc, a_q, m_q, b_q[W-1]);
         b_nx   = b_q << 1;
         cnt_nx = cnt - CW'(1);
         if (cnt == CW'(1)) begin
            ms_nx   = M_IDLE;
            done_nx = 1'b1;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ms   <= M_IDLE;
         cnt  <= '0;
         acc  <= '0;
         a_q  <= '0;
         b_q  <= '0;
         m_q  <= '0;
         done <= 1'b0;
      end else begin
         ms   <= ms_nx;
         cnt  <= cnt_nx;
         acc  <= acc_nx;
         a_q  <= a_nx;
         b_q  <= b_nx;
         m_q  <= m_nx;
         done <= done_nx;
      end
   end

   assign p = acc[W-1:0];

endmodule

// File: rtl/mod_pow_unit.sv
// Modular exponentiation engine: result = base^exp mod modulus (modulus 0 = 2^W).
// LSB-first square-and-multiply on top of the interleaved multiplier; the base is
// first reduced as 1*base mod m so every multiplicand stays below m.
module mod_pow_unit
   import pow_pkg::*;
#(
   parameter int W = 16,
   parameter int E = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] base,
   input  logic [E-1:0] exp,
   input  logic [W-1:0] modulus,
   input  logic         abort,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result
);

   localparam logic [W:0]   M_WRAP = {1'b1, {W{1'b0}}};
   localparam logic [W-1:0] ONE    = W'(1);

   pow_state_t   state, state_nx;
   logic [E-1:0] n, n_nx;
   logic [W-1:0] a_r, a_nx;
   logic [W-1:0] x_r, x_nx;
   logic [W-1:0] base_r, base_nx;
   logic [W:0]   mod_r, mod_nx;
   logic [W-1:0] res_nx;
   logic         kick, kick_nx;

   logic         mu_start, mu_clear, mu_done;
   logic [W-1:0] mu_a, mu_b, mu_p;
   logic [W-1:0] a_upd, x_upd;

   mod_mult #(.W(W)) u_mult (
      .clk   (clk),
      .rst   (rst),
      .start (mu_start),
      .clear (mu_clear),
      .a     (mu_a),
      .b     (mu_b),
      .m     (mod_r),
      .done  (mu_done),
      .p     (mu_p)
   );

   // FSM next-state, loop decision and multiplier operand selection.
   // 'kick' launches the reduction one cycle after accept; every later multiply
   // is chained on the cycle the previous one reports done.
   always_comb begin
      state_nx = state;
      n_nx     = n;
      a_nx     = a_r;
      x_nx     = x_r;
      base_nx  = base_r;
      mod_nx   = mod_r;
      res_nx   = result;
      kick_nx  = 1'b0;
      mu_start = 1'b0;
      mu_clear = 1'b0;
      mu_a     = a_r;
      mu_b     = x_r;
      // Value of a / x once the multiply that just finished is written back.
      a_upd    = (state == MUL_A) ? mu_p : a_r;
      x_upd    = (state == MUL_A) ? x_r  : mu_p;
      case (state)
         IDLE: begin
            if (in_valid) begin
               base_nx = base;
               n_nx    = exp;
               mod_nx  = (modulus == '0) ? M_WRAP : {1'b0, modulus};
               if (modulus == ONE) begin
                  a_nx     = '0;
                  res_nx   = '0;
                  state_nx = DONE;
               end else begin
                  a_nx     = ONE;
                  kick_nx  = 1'b1;
                  state_nx = REDUCE;
               end
            end
         end
         REDUCE, MUL_A, MUL_X: begin
            if (abort) begin
               state_nx = IDLE;
               mu_clear = 1'b1;
            end else if (kick) begin
               mu_start = 1'b1;
               mu_a     = ONE;
               mu_b     = base_r;
            end else if (mu_done) begin
               a_nx = a_upd;
               x_nx = x_upd;
               if (n == '0) begin
                  state_nx = DONE;
                  res_nx   = a_upd;
               // The current bit is consumed once a MUL_A has run for it.
               end else if (n[0] && (state != MUL_A)) begin
                  state_nx = MUL_A;
                  mu_start = 1'b1;
                  mu_a     = a_upd;
                  mu_b     = x_upd;
               end else begin
                  n_nx = n >> 1;
                  if ((n >> 1) != '0) begin
                     state_nx = MUL_X;
                     mu_start = 1'b1;
                     mu_a     = x_upd;
                     mu_b     = x_upd;
                  end else begin
                     state_nx = DONE;
                     res_nx   = a_upd;
                  end
               end
            end
         end
         DONE: begin
            // Abort and consume both return to IDLE; abort simply wins the cycle.
            if (abort || out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, operand and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         n      <= '0;
         a_r    <= '0;
         x_r    <= '0;
         base_r <= '0;
         mod_r  <= '0;
         result <= '0;
         kick   <= 1'b0;
      end else begin
         state  <= state_nx;
         n      <= n_nx;
         a_r    <= a_nx;
         x_r    <= x_nx;
         base_r <= base_nx;
         mod_r  <= mod_nx;
         result <= res_nx;
         kick   <= kick_nx;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mod_pow_unit.sv
// Self-checking bench for mod_pow_unit: directed cases, handshake, abort/reset,
// then randomized requests against a plain-arithmetic reference model.
module tb_mod_pow_unit;

   localparam int W = 16;
   localparam int E = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] base = '0;
   logic [E-1:0] exp = '0;
   logic [W-1:0] modulus = '0;
   logic         abort = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mod_pow_unit #(.W(W), .E(E)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .base      (base),
      .exp       (exp),
      .modulus   (modulus),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Reference: repeated squaring with ordinary integer arithmetic.
   function automatic longint ref_pow(input logic [W-1:0] b, input logic [E-1:0] e,
                                      input logic [W-1:0] md);
      longint m, r, x, k;
      m = (md == '0) ? 64'd65536 : longint'(md);
      r = 1 % m;
      x = longint'(b) % m;
      k = longint'(e);
      while (k > 0) begin
         if (k % 2 == 1) r = (r * x) % m;
         x = (x * x) % m;
         k = k / 2;
      end
      return r;
   endfunction

   // Latency: W cycles per multiply, M = 1 + popcount + max(bitlen-1, 0), plus one.
   function automatic int ref_lat(input logic [E-1:0] e, input logic [W-1:0] md);
      int pc, bl;
      pc = 0;
      bl = 0;
      if (md == W'(1)) return 1;
      for (int i = 0; i < E; i++) begin
         if (e[i]) begin
            pc++;
            bl = i + 1;
         end
      end
      return W * (1 + pc + ((bl > 1) ? bl - 1 : 0)) + 1;
   endfunction

   // Present a request just after an edge; returns #1 after the accept edge with
   // the input bus scrambled so later input changes are exercised.
   task automatic issue(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] md);
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      base = b;
      exp = e;
      modulus = md;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      base = W'($urandom);
      exp = E'($urandom);
      modulus = W'($urandom);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!out_valid) chk("timeout_out_valid", 64'd0, 64'd1);
   endtask

   task automatic drain(input int hold, input logic [W-1:0] want);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", 64'(out_valid), 64'd1);
         chk("hold_result", 64'(result), 64'(want));
         chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_in_ready", 64'(in_ready), 64'd1);
      chk("release_out_valid", 64'(out_valid), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] b, input logic [E-1:0] e,
                         input logic [W-1:0] md, input int hold);
      int cyc;
      logic [W-1:0] want;
      want = W'(ref_pow(b, e, md));
      issue(b, e, md);
      wait_valid(cyc);
      if (out_valid) begin
         chk({tag, "_result"}, 64'(result), 64'(want));
         if (md == W'(1)) chk({tag, "_latency_le1"}, 64'(cyc <= 1), 64'd1);
         else             chk({tag, "_latency"}, 64'(cyc), 64'(ref_lat(e, md)));
         drain(hold, want);
      end
   endtask

   initial begin
      int cyc;
      bit saw;

      // Reset state, both during and after reset.
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // Directed cases.
      run_op("wrap_3_5", 16'd3, 8'd5, 16'd0, 0);
      run_op("lat_3_13", 16'd3, 8'd13, 16'd0, 0);
      run_op("unred_1000", 16'd1000, 8'd3, 16'd7, 0);
      run_op("two_pow_10", 16'd2, 8'd10, 16'd1000, 1);
      run_op("zero_zero", 16'd0, 8'd0, 16'd13, 0);
      run_op("mod_one", 16'd9, 8'd200, 16'd1, 2);
      run_op("max_wrap", 16'hFFFF, 8'd255, 16'd0, 0);

      // Back-pressure: 20 held cycles, then the next request right after release.
      run_op("backpressure", 16'd3, 8'd5, 16'd0, 20);
      run_op("after_release", 16'd2, 8'd10, 16'd1000, 0);

      // Abort in mid-operation: no result, then a fresh request still works.
      issue(16'd3, 8'd13, 16'd0);
      repeat (39) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      saw = 1'b0;
      repeat (150) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      chk("abort_no_valid", 64'(saw), 64'd0);
      run_op("after_abort", 16'd3, 8'd5, 16'd0, 0);

      // Asynchronous reset during a squaring step; result was 243 before.
      issue(16'd3, 8'd13, 16'd0);
      repeat (40) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_result", 64'(result), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run_op("after_reset", 16'd5, 8'd7, 16'd23, 0);

      // Abort together with out_ready while DONE.
      issue(16'd7, 8'd3, 16'd11);
      wait_valid(cyc);
      abort = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      out_ready = 1'b0;
      chk("abort_done_in_ready", 64'(in_ready), 64'd1);
      chk("abort_done_out_valid", 64'(out_valid), 64'd0);
      run_op("after_abort_done", 16'd7, 8'd3, 16'd11, 0);

      // Randomized requests across the modulus classes.
      for (int t = 0; t < 40; t++) begin
         logic [W-1:0] rb, rm;
         logic [E-1:0] re;
         rb = W'($urandom);
         re = E'($urandom);
         case ($urandom_range(0, 3))
            0:       rm = '0;
            1:       rm = W'(1);
            2:       rm = W'($urandom_range(2, 50));
            default: rm = W'($urandom_range(2, 65535));
         endcase
         run_op("rand", rb, re, rm, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_pow_unit.md
# mod_pow_unit

- Parametrised successor to the team's fixed-width square-and-multiply power unit.
- Computes `base^exp mod modulus` for a configurable operand width.
- A `modulus` of 0 selects plain wrap-around arithmetic, mod 2^W.
- Uses a sequential interleaved modular multiplier, valid/ready handshakes on both sides, and an abort input; it sits as a slave arithmetic engine behind the crypto/test datapath.

## Interface
- `W`, default 16: operand/result/modulus width (≥2).
- `E`, default 8: exponent width (≥1).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `base` in W: base operand, any value.
- `exp` in E: exponent.
- `modulus` in W: modulus; 0 means 2^W.
- `abort` in 1: cancel the current operation.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out W: `base^exp mod modulus`.

## Operation
- **States:**
  - IDLE: `in_ready`=1.
  - REDUCE: x = base·1 mod m.
  - MUL_A: a = a·x mod m.
  - MUL_X: x = x·x mod m.
  - DONE: `out_valid`=1.
- **Accept:** `in_valid && in_ready` at an edge latches operands, sets a=1 and n=exp.
  - Normally goes to REDUCE.
  - If modulus==1: a=0 and state goes to DONE directly.
- **Multiplier rule:** every multiply runs exactly W cycles through the sub-module.
- **Loop** (LSB-first), evaluated when the previous multiply completes:
  - If n==0 → DONE.
  - If n[0]==1 and the bit was not yet consumed → MUL_A.
  - Otherwise shift n right by 1; if the new n≠0 → MUL_X, else → DONE.
- **Multiply count:** M = 1 + popcount(exp) + max(bitlen(exp)−1, 0).
- **Arithmetic:**
  - All intermediates use W+1 bits; m=0 is represented as the (W+1)-bit value 2^W.
  - The interleaved step is r=2r, subtract m if r≥m, add a if b[i], subtract m if r≥m, for i=W−1..0.
  - Operand a is always < m, so the base is reduced without a divider.
- **Special cases:**
  - exp=0 → result 1 (0 if modulus==1).
  - 0^0 = 1.
- **DONE:** holds `result` and `out_valid` until `out_valid && out_ready`, then → IDLE.
- **Abort:**
  - In REDUCE/MUL_A/MUL_X/DONE: → IDLE next edge, no `out_valid` pulse (a pending result is discarded), multiplier cleared.
  - In IDLE: ignored.
- **Priority:** abort has priority over multiplier completion and over `out_ready` in the same cycle.
- **Input stability:** inputs are sampled only at accept; later changes have no effect.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, multiplier idle.
- **Reset mid-operation:** reset asserted in any state returns to these values immediately (asynchronously).
- **Latency:** with the accept edge as edge 0, `out_valid` is high after edge L, where L = W·M + 1.
  - modulus==1 → L=1.
- **Input side:** `in_ready`=0 from the edge after accept until the edge after the result is consumed; no back-to-back overlap.
- **Output side:** `out_valid` stays high with `result` stable while `out_ready`=0 (no timeout).
- **Outputs:** `result` is registered and changes only on entry to DONE.

## Structure
- **Shared package `pow_pkg`:**
  - state enum `pow_state_t` (IDLE, REDUCE, MUL_A, MUL_X, DONE).
  - multiplier state enum.
- **Sub-module `mod_mult #(W)`:**
  - Ports: `clk`, `rst`, `start`, `clear`, `a`, `b`, `m` (W+1 bits), `done` (one-cycle pulse after exactly W cycles), `p`.
  - Contains the bit counter and accumulator.
- **Top level:** FSM, exponent shift register, a/x registers and handshake logic.
- **Size:** roughly 120 lines for `mod_mult`, 180 for the top level.

## Test plan (W=16, E=8 unless stated)
- **Wrap mode:** base=3, exp=5, mod=0 → result 243 at L=16·(1+2+2)+1=81.
- **Latency check:** base=3, exp=13, mod=0 → result 21459 at L=16·7+1=113; check `out_valid` is low at cycle 112.
- **Unreduced base:**
  - base=1000, exp=3, mod=7 → 6.
  - base=2, exp=10, mod=1000 → 24.
- **Boundaries:**
  - base=0, exp=0, mod=13 → 1 at L=17.
  - base=9, exp=200, mod=1 → 0 at L=1.
  - base=65535, exp=255, mod=0 → 65535.
- **Handshake:**
  - Hold `out_ready`=0 for 20 cycles after `out_valid`: result stable, `in_ready`=0.
  - Release `out_ready`: `in_ready`=1 next cycle.
  - Next request accepted that cycle.
- **Abort/reset:**
  - `abort` at cycle 40 of base=3, exp=13: IDLE next edge, no `out_valid`; a fresh 3^5 then returns 243.
  - `rst` pulse mid-MUL_X: all outputs at reset values immediately.
  - Abort coincident with DONE and `out_ready`: no transfer counted.
